uio_bus_arbiter: RTL

Round-robin arbiter sharing the eight bidirectional `uio` pads of the `tt_um_killer_` tile between up to NREQ internal requesters. Only the granted requester drives `uio_out` and `uio_oe`. Every other requester sees the pads as inputs. Ownership changes are separated by a guaranteed all-tristate turnaround window, and a hold limit prevents one requester from starving the others.

---
 rtl/uio_arb_pkg.sv | 20 ++
 rtl/uio_bus_arbiter_rr_pick.sv | 29 ++
 rtl/uio_bus_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/uio_arb_pkg.sv
// Shared types and helpers for the uio pad arbiter: FSM states, lane width
// and a packed-lane slicer used by the output mux.
package uio_arb_pkg;

   localparam int LANE_W  = 8;
   localparam int MAX_REQ = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_TURN = 2'd2
   } arb_state_t;

   // Vector is always presented zero-extended to MAX_REQ lanes.
   function automatic logic [LANE_W-1:0] lane(input logic [MAX_REQ*LANE_W-1:0] vec,
                                              input logic [2:0] i);
      return vec[{i, 3'b000} +: LANE_W];
   endfunction

endpackage

// File: rtl/uio_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module rr_pick #(
   parameter int NREQ  = 4,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] last,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   int j;

   // Scan farthest-first so the nearest candidate after 'last' is written last.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      j     = 0;
      for (int k = NREQ; k >= 1; k--) begin
         j = int'(last) + k;
         if (j >= NREQ) j = j - NREQ;
         if (req[IDX_W'(j)]) begin
            valid = 1'b1;
            idx   = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the shared uio pads with a hold limit and an
// all-tristate turnaround between successive owners.
module uio_bus_arbiter
   import uio_arb_pkg::*;
#(
   parameter int NREQ        = 4,
   parameter int MAX_HOLD    = 16,
   parameter int TURN_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ena,
   input  logic [NREQ-1:0]        req,
   input  logic [8*NREQ-1:0]      req_out,
   input  logic [8*NREQ-1:0]      req_oe,
   input  logic [7:0]             uio_in,
   output logic [NREQ-1:0]        grant,
   output logic [7:0]             rd_data,
   output logic [7:0]             uio_out,
   output logic [7:0]             uio_oe,
   output logic                   busy
);

   localparam int IDX_W  = $clog2(NREQ);
   localparam int HOLD_W = $clog2(MAX_HOLD);
   localparam int TURN_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURN_CYCLES - 1);
   localparam logic [IDX_W-1:0]  LAST_RST  = IDX_W'(NREQ - 1);

   arb_state_t          state_q;
   logic [IDX_W-1:0]    owner_q;
   logic [IDX_W-1:0]    last_owner_q;
   logic [HOLD_W-1:0]   hold_cnt_q;
   logic [TURN_W-1:0]   turn_cnt_q;
   logic [NREQ-1:0]     grant_q;
   logic                busy_q;

   logic                pick_valid;
   logic [IDX_W-1:0]    pick_idx;
   logic [NREQ-1:0]     owner_oh;
   logic                others_pending;
   logic [MAX_REQ*LANE_W-1:0] out_ext;
   logic [MAX_REQ*LANE_W-1:0] oe_ext;

   rr_pick #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req   (req),
      .last  (last_owner_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   assign owner_oh       = NREQ'(1) << owner_q;
   assign others_pending = |(req & ~owner_oh);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         owner_q      <= '0;
         last_owner_q <= LAST_RST;
         hold_cnt_q   <= '0;
         turn_cnt_q   <= '0;
         grant_q      <= '0;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ena && pick_valid) begin
                  state_q      <= ST_OWN;
                  owner_q      <= pick_idx;
                  last_owner_q <= pick_idx;
                  hold_cnt_q   <= '0;
                  grant_q      <= NREQ'(1) << pick_idx;
                  busy_q       <= 1'b1;
               end
            end

            ST_OWN: begin
               if (!req[owner_q] || !ena ||
                   ((hold_cnt_q == HOLD_LAST) && others_pending)) begin
                  state_q    <= ST_TURN;
                  turn_cnt_q <= TURN_LOAD;
                  grant_q    <= '0;
               end else if (hold_cnt_q == HOLD_LAST) begin
                  // Uncontested owner: restart the hold window instead of releasing.
                  hold_cnt_q <= '0;
               end else begin
                  hold_cnt_q <= hold_cnt_q + 1'b1;
               end
            end

            ST_TURN: begin
               if (turn_cnt_q == '0) begin
                  if (ena && pick_valid) begin
                     state_q      <= ST_OWN;
                     owner_q      <= pick_idx;
                     last_owner_q <= pick_idx;
                     hold_cnt_q   <= '0;
                     grant_q      <= NREQ'(1) << pick_idx;
                  end else begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  turn_cnt_q <= turn_cnt_q - 1'b1;
               end
            end

            default: begin
               state_q <= ST_IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      out_ext = '0;
      oe_ext  = '0;
      out_ext[8*NREQ-1:0] = req_out;
      oe_ext[8*NREQ-1:0]  = req_oe;
   end

   // Pads follow the owner combinationally, but only while the FSM says OWN.
   assign uio_out = (state_q == ST_OWN) ? lane(out_ext, 3'(owner_q)) : 8'h00;
   assign uio_oe  = (state_q == ST_OWN) ? lane(oe_ext, 3'(owner_q))  : 8'h00;
   assign grant   = grant_q;
   assign busy    = busy_q;
   assign rd_data = uio_in;

endmodule
